// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the PE command path. It holds the opcode field
// positions, the class/func encodings understood by pe_core_single, the packed
// command record stored in the command FIFO, and a helper that builds an opcode
// word from a class and a func.
// -----------------------------------------------------------------------------
package pe_pkg;

    // Opcode layout: {class[31:25], func[24:20], 20'd0}
    localparam int CLASS_MSB = 31;
    localparam int CLASS_LSB = 25;
    localparam int FUNC_MSB  = 24;
    localparam int FUNC_LSB  = 20;

    // Classes and the functions within each class
    localparam logic [6:0] ARITH = 7'b0000001;
    localparam logic [4:0] ADD   = 5'b00001;
    localparam logic [4:0] SUB   = 5'b00010;
    localparam logic [4:0] MUL   = 5'b00011;
    localparam logic [6:0] ACT   = 7'b0000010;
    localparam logic [4:0] RELU  = 5'b01011;
    localparam logic [6:0] CMP   = 7'b0010000;
    localparam logic [4:0] EQ    = 5'b00001;

    // One queued PE command (128 bits)
    typedef struct packed {
        logic [31:0] opcode;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op3;
    } pe_cmd_t;

    function automatic logic [31:0] make_opcode(input logic [6:0] cls,
                                                input logic [4:0] func);
        return {cls, func, 20'd0};
    endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// -----------------------------------------------------------------------------
// pe_sync_fifo
// Single-clock FIFO with an occupancy count. The head entry is visible on
// data_o whenever empty_o is low. A push while full or a pop while empty is
// ignored.
//   clk, rst_n       clock, asynchronous active-low reset
//   push_i, data_i   write request and data
//   pop_i            read request (advances the head)
//   data_o           current head entry
//   full_o, empty_o  occupancy flags
//   count_o          number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module pe_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: the storage array has no reset; empty_o/count_o already mark every
    // slot invalid, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/pe_cmd_issuer.sv
// -----------------------------------------------------------------------------
// pe_cmd_issuer
// Command-side master for pe_core_single. It queues controller commands, issues
// them to the PE under credit control, tags the in-order results and queues them
// for downstream. A watchdog abandons outstanding work if the PE hangs.
//   cmd_*      upstream command valid/ready with opcode and three operands
//   pe_*       registered PE inputs (pe_valid_in pulses once per issue) and
//              the PE result return path
//   rsp_*      downstream response valid/ready with result and issue-order tag
//   busy       any command queued, in flight or buffered
//   err_*      sticky timeout / spurious-result flags; err_clr clears both
// -----------------------------------------------------------------------------
module pe_cmd_issuer
    import pe_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_opcode,
    input  logic [31:0]      cmd_op1,
    input  logic [31:0]      cmd_op2,
    input  logic [31:0]      cmd_op3,
    output logic [31:0]      pe_opcode,
    output logic [31:0]      pe_op1,
    output logic [31:0]      pe_op2,
    output logic [31:0]      pe_op3,
    output logic             pe_valid_in,
    input  logic [31:0]      pe_result_out,
    input  logic             pe_result_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_spurious,
    input  logic             err_clr
);

    localparam int CW   = $clog2(RSP_DEPTH);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [CW+1:0]   CREDIT  = (CW+2)'(RSP_DEPTH);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // Command FIFO
    pe_cmd_t cmd_head;
    logic    cmd_full, cmd_empty, cmd_push;
    logic [$clog2(CMD_DEPTH):0] cmd_count_unused;

    // Response FIFO
    logic [32+TAG_W-1:0] rsp_head;
    logic                rsp_empty, rsp_pop, rsp_full_unused;
    logic [CW:0]         rsp_count;

    // State
    logic             ready_q;
    pe_cmd_t          pe_cmd_q;
    logic             pe_valid_q;
    logic [CW:0]      inflight_q, inflight_d;
    logic [TAG_W-1:0] itag_q, itag_d, rtag_q, rtag_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_to_q, err_to_d, err_sp_q, err_sp_d;

    logic issue, res_accept, res_spurious, wd_fire;

    // ready_q holds cmd_ready low through reset and for the first edge after it.
    assign cmd_ready = ready_q && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    pe_sync_fifo #(.WIDTH($bits(pe_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_push),
        .data_i  ({cmd_opcode, cmd_op1, cmd_op2, cmd_op3}),
        .pop_i   (issue),
        .data_o  (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count_unused)
    );

    // Credit accounting guarantees room, so full is never needed here.
    pe_sync_fifo #(.WIDTH(32 + TAG_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (res_accept),
        .data_i  ({pe_result_out, rtag_q}),
        .pop_i   (rsp_pop),
        .data_o  (rsp_head),
        .full_o  (rsp_full_unused),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    // Issue only when every outstanding and buffered result still fits.
    assign issue        = !cmd_empty &&
                          (({1'b0, inflight_q} + {1'b0, rsp_count}) < CREDIT);
    assign res_accept   = pe_result_valid && (inflight_q != '0);
    assign res_spurious = pe_result_valid && (inflight_q == '0);
    assign wd_fire      = (inflight_q != '0) && !pe_result_valid && (wd_q == WD_LAST);

    // NOTE: every variable gets a default at the top of this always_comb, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        inflight_d = inflight_q;
        itag_d     = itag_q;
        rtag_d     = rtag_q;
        wd_d       = wd_q + 1'b1;
        err_to_d   = (err_to_q && !err_clr) || wd_fire;
        err_sp_d   = (err_sp_q && !err_clr) || res_spurious;

        if (issue) itag_d = itag_q + 1'b1;

        if (wd_fire) begin
            // Abandon all outstanding work; skip their tags so rtag catches up
            // with itag. A same-cycle issue becomes the only in-flight command.
            inflight_d = issue ? (CW+1)'(1) : '0;
            rtag_d     = rtag_q + TAG_W'(inflight_q);
        end else begin
            case ({issue, res_accept})
                2'b10:   inflight_d = inflight_q + 1'b1;
                2'b01:   inflight_d = inflight_q - 1'b1;
                default: inflight_d = inflight_q;
            endcase
            if (res_accept) rtag_d = rtag_q + 1'b1;
        end

        if ((inflight_q == '0) || pe_result_valid || wd_fire) wd_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            pe_cmd_q   <= '0;
            pe_valid_q <= 1'b0;
            inflight_q <= '0;
            itag_q     <= '0;
            rtag_q     <= '0;
            wd_q       <= '0;
            err_to_q   <= 1'b0;
            err_sp_q   <= 1'b0;
        end else begin
            ready_q    <= 1'b1;
            pe_valid_q <= issue;
            if (issue) pe_cmd_q <= cmd_head;
            inflight_q <= inflight_d;
            itag_q     <= itag_d;
            rtag_q     <= rtag_d;
            wd_q       <= wd_d;
            err_to_q   <= err_to_d;
            err_sp_q   <= err_sp_d;
        end
    end

    assign pe_opcode    = pe_cmd_q.opcode;
    assign pe_op1       = pe_cmd_q.op1;
    assign pe_op2       = pe_cmd_q.op2;
    assign pe_op3       = pe_cmd_q.op3;
    assign pe_valid_in  = pe_valid_q;

    // The head is gated so outputs read zero while the FIFO is empty.
    assign rsp_data     = rsp_valid ? rsp_head[32+TAG_W-1:TAG_W] : '0;
    assign rsp_tag      = rsp_valid ? rsp_head[TAG_W-1:0] : '0;

    assign busy         = !cmd_empty || (inflight_q != '0) || !rsp_empty;
    assign err_timeout  = err_to_q;
    assign err_spurious = err_sp_q;

endmodule

// File: tb/tb_pe_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_pe_cmd_issuer
// Directed bench for pe_cmd_issuer. A small behavioural PE (fixed three-cycle
// latency) answers issued commands; it can be muted to imitate a hung PE, or
// forced to raise result_valid while idle.
// -----------------------------------------------------------------------------
module tb_pe_cmd_issuer;
    import pe_pkg::*;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_opcode, cmd_op1, cmd_op2, cmd_op3;
    logic [31:0]      pe_opcode, pe_op1, pe_op2, pe_op3;
    logic             pe_valid_in;
    logic [31:0]      pe_result_out;
    logic             pe_result_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic             err_timeout;
    logic             err_spurious;
    logic             err_clr;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int base, k, n;
    logic acc;

    always #5 clk = ~clk;

    pe_cmd_issuer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_opcode      (cmd_opcode),
        .cmd_op1         (cmd_op1),
        .cmd_op2         (cmd_op2),
        .cmd_op3         (cmd_op3),
        .pe_opcode       (pe_opcode),
        .pe_op1          (pe_op1),
        .pe_op2          (pe_op2),
        .pe_op3          (pe_op3),
        .pe_valid_in     (pe_valid_in),
        .pe_result_out   (pe_result_out),
        .pe_result_valid (pe_result_valid),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_tag         (rsp_tag),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .err_spurious    (err_spurious),
        .err_clr         (err_clr)
    );

    // ---------------- behavioural PE ----------------
    logic        pe_mute, pe_force;
    logic [2:0]  pipe_v;
    logic [31:0] pipe_d [3];

    function automatic logic [31:0] pe_eval(input logic [31:0] opc,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [11:0] key;
        key = {opc[CLASS_MSB:CLASS_LSB], opc[FUNC_MSB:FUNC_LSB]};
        case (key)
            {ARITH, ADD}: return a + b;
            {ARITH, SUB}: return a - b;
            {ARITH, MUL}: return a * b;
            {ACT, RELU}:  return ($signed(a) < 0) ? 32'd0 : a;
            {CMP, EQ}:    return {31'd0, (a == b)};
            default:      return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < 3; i++) pipe_d[i] <= '0;
        end else begin
            pipe_v    <= {pipe_v[1:0], pe_valid_in};
            pipe_d[0] <= pe_eval(pe_opcode, pe_op1, pe_op2);
            pipe_d[1] <= pipe_d[0];
            pipe_d[2] <= pipe_d[1];
        end
    end

    assign pe_result_valid = (pipe_v[2] && !pe_mute) || pe_force;
    assign pe_result_out   = pipe_d[2];

    always @(posedge clk) begin
        if (pe_valid_in) issue_cnt <= issue_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_op1 = '0; cmd_op2 = '0; cmd_op3 = '0;
        rsp_ready = 1'b0; err_clr = 1'b0; pe_mute = 1'b0; pe_force = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Present one command and hold it until accepted (bounded).
    task automatic send(input logic [31:0] opc, input logic [31:0] a, input logic [31:0] b);
        cmd_valid = 1'b1; cmd_opcode = opc; cmd_op1 = a; cmd_op2 = b; cmd_op3 = 32'd0;
        for (int i = 0; i < 200 && !cmd_ready; i++) tick();
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait for a response (bounded), compare it, then pop it.
    task automatic expect_rsp(input string name, input logic [31:0] data, input logic [31:0] tag);
        for (int i = 0; i < 200 && !rsp_valid; i++) tick();
        check({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({name, "_data"}, rsp_data, data);
        check({name, "_tag"}, {28'd0, rsp_tag}, tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values while reset is held
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_op1 = '0; cmd_op2 = '0; cmd_op3 = '0;
        rsp_ready = 1'b0; err_clr = 1'b0; pe_mute = 1'b0; pe_force = 1'b0;
        tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_pe_valid", {31'd0, pe_valid_in}, 32'd0);
        check("rst_pe_opcode", pe_opcode, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_errs", {30'd0, err_timeout, err_spurious}, 32'd0);
        rst_n = 1'b1;
        check("rel_cmd_ready_0", {31'd0, cmd_ready}, 32'd0);
        tick();
        check("rel_cmd_ready_1", {31'd0, cmd_ready}, 32'd1);

        // Single ADD 10+20: two-cycle accept-to-issue latency, one pulse
        base = issue_cnt;
        send(make_opcode(ARITH, ADD), 32'd10, 32'd20);
        check("add_no_issue_yet", {31'd0, pe_valid_in}, 32'd0);
        tick();
        check("add_pe_valid", {31'd0, pe_valid_in}, 32'd1);
        check("add_pe_opcode", pe_opcode, 32'h0210_0000);
        check("add_pe_op1", pe_op1, 32'd10);
        check("add_pe_op2", pe_op2, 32'd20);
        tick();
        check("add_pe_valid_drop", {31'd0, pe_valid_in}, 32'd0);
        check("add_op1_hold", pe_op1, 32'd10);
        expect_rsp("add", 32'd30, 32'd0);
        check("add_one_issue", issue_cnt - base, 32'd1);
        check("add_idle", {31'd0, busy}, 32'd0);

        // Back-to-back four commands; issues on four consecutive cycles
        do_reset();
        base = issue_cnt;
        send(make_opcode(ARITH, SUB), 32'd50, 32'd20);
        send(make_opcode(ARITH, MUL), 32'd12, 32'd5);
        check("b2b_v1", {31'd0, pe_valid_in}, 32'd1);
        send(make_opcode(ACT, RELU), -32'd25, 32'd0);
        check("b2b_v2", {31'd0, pe_valid_in}, 32'd1);
        send(make_opcode(CMP, EQ), 32'd42, 32'd42);
        check("b2b_v3", {31'd0, pe_valid_in}, 32'd1);
        tick();
        check("b2b_v4", {31'd0, pe_valid_in}, 32'd1);
        tick();
        check("b2b_v_end", {31'd0, pe_valid_in}, 32'd0);
        expect_rsp("sub", 32'd30, 32'd0);
        expect_rsp("mul", 32'd60, 32'd1);
        expect_rsp("relu", 32'd0, 32'd2);
        expect_rsp("eq", 32'd1, 32'd3);
        check("b2b_issues", issue_cnt - base, 32'd4);

        // Backpressure: rsp_ready low, 10 commands offered
        do_reset();
        base = issue_cnt;
        k = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            cmd_valid = (k < 10); cmd_opcode = make_opcode(ARITH, ADD);
            cmd_op1 = 32'd100; cmd_op2 = k; cmd_op3 = 32'd0;
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) k++;
        end
        check("bp_accepted", k, 32'd8);
        check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("bp_issues", issue_cnt - base, 32'd4);
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        n = 0;
        fork
            begin
                for (int cyc = 0; cyc < 200 && k < 10; cyc++) begin
                    cmd_valid = 1'b1; cmd_op2 = k;
                    acc = cmd_ready;
                    tick();
                    if (acc) k++;
                end
                cmd_valid = 1'b0;
            end
            begin
                rsp_ready = 1'b1;
                for (int cyc = 0; cyc < 300 && n < 10; cyc++) begin
                    if (rsp_valid) begin
                        check($sformatf("bp_data_%0d", n), rsp_data, 32'd100 + n);
                        check($sformatf("bp_tag_%0d", n), {28'd0, rsp_tag}, n % 16);
                        n++;
                    end
                    tick();
                end
                rsp_ready = 1'b0;
            end
        join
        check("bp_rsp_count", n, 32'd10);
        check("bp_issues_total", issue_cnt - base, 32'd10);
        check("bp_idle", {31'd0, busy}, 32'd0);

        // Hung PE: watchdog fires 64 cycles after the issue edge
        do_reset();
        pe_mute = 1'b1;
        send(make_opcode(ARITH, ADD), 32'd3, 32'd4);
        tick();
        check("to_issue", {31'd0, pe_valid_in}, 32'd1);
        repeat (63) tick();
        check("to_not_yet", {31'd0, err_timeout}, 32'd0);
        tick();
        check("to_fired", {31'd0, err_timeout}, 32'd1);
        check("to_inflight_zero", {31'd0, busy}, 32'd0);
        pe_mute = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_cleared", {31'd0, err_timeout}, 32'd0);
        send(make_opcode(ARITH, ADD), 32'd3, 32'd4);
        expect_rsp("to_next", 32'd7, 32'd1);

        // Spurious result while idle
        do_reset();
        pe_force = 1'b1;
        tick();
        pe_force = 1'b0;
        check("sp_flag", {31'd0, err_spurious}, 32'd1);
        check("sp_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("sp_no_timeout", {31'd0, err_timeout}, 32'd0);
        tick();
        check("sp_sticky", {31'd0, err_spurious}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("sp_cleared", {31'd0, err_spurious}, 32'd0);
        send(make_opcode(ARITH, ADD), 32'd1, 32'd1);
        expect_rsp("sp_next", 32'd2, 32'd0);

        // Reset mid-operation: 2 buffered, 2 in flight, 3 queued
        do_reset();
        send(make_opcode(ARITH, ADD), 32'd1, 32'd1);
        send(make_opcode(ARITH, ADD), 32'd2, 32'd2);
        repeat (10) tick();
        pe_mute = 1'b1;
        for (int i = 0; i < 5; i++) send(make_opcode(ARITH, SUB), 32'd9, i);
        repeat (3) tick();
        check("mr_issues_stalled", {31'd0, cmd_ready}, 32'd1);
        check("mr_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("mr_pe_op1", pe_op1, 32'd0);
        check("mr_rsp_data", rsp_data, 32'd0);
        tick();
        rst_n = 1'b1;
        pe_mute = 1'b0;
        tick();
        check("mr_after_busy", {31'd0, busy}, 32'd0);
        send(make_opcode(ARITH, ADD), 32'd5, 32'd6);
        expect_rsp("mr_first", 32'd11, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_cmd_issuer.md
Name: pe_cmd_issuer

Overview:
Command-side master for pe_core_single. It accepts PE commands (opcode plus three operands) from a controller over a valid/ready interface, buffers them, and drives the PE's opcode/op1/op2/op3/valid_in inputs. It captures result_out/result_valid, attaches in-order tags, and returns results downstream over valid/ready. Credit accounting ensures no PE result is ever dropped, and a watchdog flags a hung PE.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
RSP_DEPTH, 4, response FIFO entries (power of two, >=2); also the maximum number of in-flight plus buffered results
TAG_W, 4, response tag width
TIMEOUT, 64, cycles without a result while in-flight>0 before err_timeout is raised

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  upstream command valid
cmd_ready  out  1  command FIFO not full
cmd_opcode  in  32  {class[31:25], func[24:20], 20'd0}
cmd_op1  in  32  operand 1
cmd_op2  in  32  operand 2
cmd_op3  in  32  operand 3
pe_opcode  out  32  to PE opcode
pe_op1  out  32  to PE op1
pe_op2  out  32  to PE op2
pe_op3  out  32  to PE op3
pe_valid_in  out  1  to PE valid_in, one-cycle pulse per command
pe_result_out  in  32  from PE result_out
pe_result_valid  in  1  from PE result_valid
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  downstream accept
rsp_data  out  32  result
rsp_tag  out  TAG_W  issue-order tag
busy  out  1  cmd FIFO non-empty or in-flight>0 or rsp FIFO non-empty
err_timeout  out  1  sticky watchdog error
err_spurious  out  1  sticky: result received with in-flight==0
err_clr  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset: all outputs 0. Exceptions: cmd_ready=1 one cycle after reset release; pe_* registers=0. FIFOs empty, in-flight=0, tags=0, watchdog=0. Reset mid-operation discards all queued, in-flight and buffered data.
- Command push: occurs when cmd_valid && cmd_ready. cmd_ready = !cmd_full; there is no combinational path from cmd_valid.
- Issue condition: cmd FIFO non-empty && (inflight + rsp_count) < RSP_DEPTH. On issue, pop the FIFO and register the fields onto pe_*; pe_valid_in=1 for exactly that cycle, else 0. pe_op* hold their last value when idle. Maximum rate is one issue per cycle. Latency from cmd accept to pe_valid_in is 2 cycles (FIFO write, then issue register).
- In-flight counter: width clog2(RSP_DEPTH)+1. Increments on issue, decrements on pe_result_valid; when both occur in the same cycle it is unchanged.
- PE contract: the result arrives in order, one result per command, PE latency is arbitrary but at most TIMEOUT.
- Result capture: on pe_result_valid with inflight>0, push {pe_result_out, rtag} into the rsp FIFO, then rtag++ (wraps mod 2^TAG_W). Credit guarantees the FIFO has room. A simultaneous rsp pop is allowed.
- Spurious result: pe_result_valid with inflight==0 is dropped, sets err_spurious, and leaves rtag unchanged.
- Response side: rsp_valid = !rsp_empty; rsp_data/rsp_tag show the FIFO head; pop on rsp_valid && rsp_ready. A stalled rsp_ready throttles issue via credit, never loses data.
- Watchdog:
  - Counts cycles where inflight>0 && !pe_result_valid.
  - Resets to 0 on any result or when inflight==0.
  - On reaching TIMEOUT: set err_timeout, force inflight=0 (abandon outstanding), advance rtag by the abandoned count so later tags stay aligned with issue order.
  - Issue continues afterwards.
- err_clr: clears both sticky errors next cycle. If an error event happens in the same cycle, the set wins.
- Tags: issue tag itag++ per issue. Invariant: rtag==itag whenever inflight==0.

Decomposition:
- pe_pkg: opcode field positions (CLASS_MSB=31, CLASS_LSB=25, FUNC_MSB=24, FUNC_LSB=20) and class/func constants (ARITH=7'b0000001, ADD=5'b00001, SUB=5'b00010, MUL=5'b00011, ACT=7'b0000010, RELU=5'b01011, CMP=7'b0010000, EQ=5'b00001).
- Sub-module pe_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice: command FIFO width 128, response FIFO width 32+TAG_W.

Test Plan:
- Single ADD (class 0000001, func 00001, op1=10, op2=20) with a pe_core_single instance and rsp_ready=1 -> pe_valid_in pulses once; rsp_valid with rsp_data=30, rsp_tag=0.
- Back-to-back SUB 50-20, MUL 12*5, RELU -25, EQ 42==42 pushed on consecutive cycles -> responses 30, 60, 0, 1 with tags 0, 1, 2, 3 in order and pe_valid_in high 4 consecutive cycles.
- rsp_ready=0 and 10 commands offered -> exactly 4 issues, cmd_ready drops after the cmd FIFO fills (4 more), no drops; after rsp_ready=1, all 10 responses arrive, tags 0..9 wrapping correctly.
- PE model that never asserts result_valid, one command issued -> err_timeout=1 exactly TIMEOUT=64 cycles after the issue cycle, inflight returns to 0; err_clr -> err_timeout=0; the next ADD returns tag 1.
- pe_result_valid forced high while idle -> err_spurious=1, no rsp_valid, rtag stays 0.
- rst_n asserted with 3 commands queued and 2 in flight -> all outputs 0 immediately; after release busy=0 and the first new response has tag 0.
